// File: rtl/span_pixel_writer.sv
// span_pixel_writer: single-pixel and horizontal-span fills, plus full-screen
// clears, turned into masked, burst-packed MCB write traffic (8bpp RGB332).
//
// Ports
//   clk, rst             clock, async active-high reset
//   clear_req/clear_rgb  clear whole screen to a colour; clear_done = idle of clears
//   req_*                draw request (valid/ready), req_drop pulses on discard
//   mem_cmd_*            MCB command port (write only)
//   mem_wr_*             MCB write-data port, mask bit k = pixel x%4==k not written
module span_pixel_writer #(
  parameter int X_W         = 8,
  parameter int Y_W         = 8,
  parameter int SCREEN_H    = 192,
  parameter int BURST_WORDS = 64,
  parameter logic [29-X_W-Y_W:0] MEM_PREFIX = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear_req,
  input  logic [7:0]     clear_rgb,
  output logic           clear_done,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_span,
  input  logic [7:0]     req_rgb,
  input  logic [X_W-1:0] req_x,
  input  logic [Y_W-1:0] req_y,
  input  logic [X_W:0]   req_len,
  output logic           req_drop,
  output logic           mem_cmd_en,
  output logic [2:0]     mem_cmd_instr,
  output logic [5:0]     mem_cmd_bl,
  output logic [29:0]    mem_cmd_byte_addr,
  input  logic           mem_cmd_full,
  output logic           mem_wr_en,
  output logic [3:0]     mem_wr_mask,
  output logic [31:0]    mem_wr_data,
  input  logic           mem_wr_full
);

  localparam int WD_W = X_W - 2;

  localparam logic [X_W+1:0] ROW_PX   = (X_W+2)'(2**X_W);
  localparam logic [X_W+1:0] PX_ONE   = (X_W+2)'(1);
  localparam logic [Y_W-1:0] LAST_ROW = Y_W'(SCREEN_H - 1);
  localparam logic [Y_W-1:0] Y_ONE    = Y_W'(1);
  localparam logic [WD_W-1:0] W_ONE   = WD_W'(1);
  localparam logic [5:0]     BL_MAX   = 6'(BURST_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, CLR_DATA, CLR_CMD, SPAN_DATA, SPAN_CMD
  } state_t;

  state_t          state_q, state_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic [WD_W-1:0] word_q, word_d;
  logic [WD_W-1:0] w0_q, w0_d;
  logic [WD_W-1:0] w1_q, w1_d;
  logic [WD_W-1:0] bstart_q, bstart_d;
  logic [5:0]      bcnt_q, bcnt_d;
  logic [1:0]      fl_q, fl_d;
  logic [1:0]      el_q, el_d;
  logic [7:0]      rgb_q, rgb_d;
  logic            fin_q, fin_d;
  logic            pend_q, pend_d;
  logic [7:0]      prgb_q, prgb_d;
  logic            done_q, done_d;
  logic            drop_q, drop_d;
  logic [5:0]      bl_q, bl_d;
  logic [29:0]     addr_q, addr_d;
  logic [3:0]      mask_q, mask_d;
  logic [31:0]     data_q, data_d;

  logic [X_W+1:0]  sum_c, end_c;
  logic [X_W-1:0]  last_c;
  logic            bad_c;
  logic            go_free;
  logic [7:0]      ccol;

  // Masked lanes: below the first pixel on the first word,
  // above the last pixel on the last word.
  function automatic logic [3:0] lane_mask(
    input logic [WD_W-1:0] w,
    input logic [WD_W-1:0] a0,
    input logic [WD_W-1:0] a1,
    input logic [1:0]      f,
    input logic [1:0]      e
  );
    logic [3:0] m;
    m = '0;
    if (w == a0) m = m | 4'((5'd1 << f) - 5'd1);
    if (w == a1) m = m | 4'(~((5'd2 << e) - 5'd1));
    return m;
  endfunction

  assign mem_wr_en = (state_q == CLR_DATA || state_q == SPAN_DATA)
                     && !mem_wr_full && !rst;
  assign mem_cmd_en = (state_q == CLR_CMD || state_q == SPAN_CMD)
                      && !mem_cmd_full && !rst;
  assign req_ready = (state_q == IDLE) && done_q && !clear_req;

  assign mem_cmd_instr     = 3'b000;
  assign mem_cmd_bl        = bl_q;
  assign mem_cmd_byte_addr = addr_q;
  assign mem_wr_mask       = mask_q;
  assign mem_wr_data       = data_q;
  assign clear_done        = done_q;
  assign req_drop          = drop_q;

  // Request decode: clipped span end and last pixel.
  always_comb begin
    sum_c = {2'b00, req_x} + {1'b0, req_len};
    if (!req_span) end_c = {2'b00, req_x} + PX_ONE;
    else if (sum_c > ROW_PX) end_c = ROW_PX;
    else end_c = sum_c;
    last_c = X_W'(end_c - PX_ONE);
    bad_c = (req_y > LAST_ROW) || (req_span && req_len == '0);
  end

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    word_d   = word_q;
    w0_d     = w0_q;
    w1_d     = w1_q;
    bstart_d = bstart_q;
    bcnt_d   = bcnt_q;
    fl_d     = fl_q;
    el_d     = el_q;
    rgb_d    = rgb_q;
    fin_d    = fin_q;
    pend_d   = pend_q;
    prgb_d   = prgb_q;
    done_d   = done_q;
    drop_d   = 1'b0;
    bl_d     = bl_q;
    addr_d   = addr_q;
    mask_d   = mask_q;
    data_d   = data_q;
    go_free  = 1'b0;
    ccol     = clear_req ? clear_rgb : prgb_q;

    if (clear_req) begin
      pend_d = 1'b1;
      prgb_d = clear_rgb;
      done_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (clear_req || pend_q) begin
          go_free = 1'b1;
        end else if (req_valid && req_ready) begin
          if (bad_c) begin
            drop_d = 1'b1;
          end else begin
            state_d  = SPAN_DATA;
            y_d      = req_y;
            w0_d     = req_x[X_W-1:2];
            w1_d     = last_c[X_W-1:2];
            word_d   = req_x[X_W-1:2];
            bstart_d = req_x[X_W-1:2];
            bcnt_d   = '0;
            fl_d     = req_x[1:0];
            el_d     = last_c[1:0];
            rgb_d    = req_rgb;
            data_d   = {4{req_rgb}};
            mask_d   = lane_mask(req_x[X_W-1:2], req_x[X_W-1:2],
                                 last_c[X_W-1:2], req_x[1:0], last_c[1:0]);
          end
        end
      end
      CLR_DATA, SPAN_DATA: begin
        if (mem_wr_en) begin
          bcnt_d = bcnt_q + 6'd1;
          word_d = word_q + W_ONE;
          mask_d = lane_mask(word_q + W_ONE, w0_q, w1_q, fl_q, el_q);
          if (word_q == w1_q || bcnt_q == BL_MAX) begin
            state_d = (state_q == CLR_DATA) ? CLR_CMD : SPAN_CMD;
            bl_d    = bcnt_q;
            addr_d  = {MEM_PREFIX, y_q, bstart_q, 2'b00};
            fin_d   = (word_q == w1_q);
          end
        end
      end
      SPAN_CMD: begin
        if (mem_cmd_en) begin
          if (fin_q) begin
            go_free = 1'b1;
          end else begin
            state_d  = SPAN_DATA;
            bstart_d = word_q;
            bcnt_d   = '0;
          end
        end
      end
      CLR_CMD: begin
        if (mem_cmd_en) begin
          if (clear_req || pend_q) begin
            go_free = 1'b1;
          end else if (fin_q && y_q == LAST_ROW) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            // word_q has already wrapped to 0 at the end of a row
            state_d  = CLR_DATA;
            bstart_d = word_q;
            bcnt_d   = '0;
            if (fin_q) y_d = y_q + Y_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Between requests/bursts: a pending clear (re)starts at row 0.
    if (go_free) begin
      if (clear_req || pend_q) begin
        state_d  = CLR_DATA;
        y_d      = '0;
        word_d   = '0;
        w0_d     = '0;
        w1_d     = '1;
        bstart_d = '0;
        bcnt_d   = '0;
        fl_d     = 2'd0;
        el_d     = 2'd3;
        rgb_d    = ccol;
        data_d   = {4{ccol}};
        mask_d   = 4'b0000;
        pend_d   = 1'b0;
        done_d   = 1'b0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CLR_DATA;
      y_q      <= '0;
      word_q   <= '0;
      w0_q     <= '0;
      w1_q     <= '1;
      bstart_q <= '0;
      bcnt_q   <= '0;
      fl_q     <= 2'd0;
      el_q     <= 2'd3;
      rgb_q    <= 8'h00;
      fin_q    <= 1'b0;
      pend_q   <= 1'b0;
      prgb_q   <= 8'h00;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
      bl_q     <= '0;
      addr_q   <= '0;
      mask_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      word_q   <= word_d;
      w0_q     <= w0_d;
      w1_q     <= w1_d;
      bstart_q <= bstart_d;
      bcnt_q   <= bcnt_d;
      fl_q     <= fl_d;
      el_q     <= el_d;
      rgb_q    <= rgb_d;
      fin_q    <= fin_d;
      pend_q   <= pend_d;
      prgb_q   <= prgb_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
      bl_q     <= bl_d;
      addr_q   <= addr_d;
      mask_q   <= mask_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: tb/tb_span_pixel_writer.sv
// tb_span_pixel_writer: table-driven requests with a scoreboard of expected
// write words and commands, plus clear/reset sequences.
module tb_span_pixel_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_req = 1'b0;
  logic [7:0]  clear_rgb = 8'h00;
  logic        clear_done;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_span = 1'b0;
  logic [7:0]  req_rgb = 8'h00;
  logic [7:0]  req_x = 8'h00;
  logic [7:0]  req_y = 8'h00;
  logic [8:0]  req_len = 9'h0;
  logic        req_drop;
  logic        mem_cmd_en;
  logic [2:0]  mem_cmd_instr;
  logic [5:0]  mem_cmd_bl;
  logic [29:0] mem_cmd_byte_addr;
  logic        mem_cmd_full = 1'b0;
  logic        mem_wr_en;
  logic [3:0]  mem_wr_mask;
  logic [31:0] mem_wr_data;
  logic        mem_wr_full = 1'b0;

  always #5 clk = ~clk;

  span_pixel_writer dut (
    .clk(clk), .rst(rst),
    .clear_req(clear_req), .clear_rgb(clear_rgb), .clear_done(clear_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_span(req_span),
    .req_rgb(req_rgb), .req_x(req_x), .req_y(req_y), .req_len(req_len),
    .req_drop(req_drop),
    .mem_cmd_en(mem_cmd_en), .mem_cmd_instr(mem_cmd_instr),
    .mem_cmd_bl(mem_cmd_bl), .mem_cmd_byte_addr(mem_cmd_byte_addr),
    .mem_cmd_full(mem_cmd_full),
    .mem_wr_en(mem_wr_en), .mem_wr_mask(mem_wr_mask),
    .mem_wr_data(mem_wr_data), .mem_wr_full(mem_wr_full)
  );

  typedef struct packed { logic [3:0] m; logic [31:0] d; } wexp_t;
  typedef struct packed { logic [5:0] bl; logic [29:0] a; } cexp_t;

  typedef struct {
    bit         span;
    int         x;
    int         y;
    int         len;
    logic [7:0] rgb;
    bit         rf;
    int         nw;
    bit         drop;
    logic [3:0] m0;
    logic [3:0] m1;
  } vec_t;

  wexp_t exp_w[$];
  cexp_t exp_c[$];
  int    tests = 0;
  int    fails = 0;
  int    words_seen = 0;
  int    drops_seen = 0;
  int    pend_words = 0;
  logic [3:0] first_m = 4'h0;
  logic [3:0] last_m = 4'h0;
  bit    rand_full = 1'b0;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    wexp_t ew;
    cexp_t ec;
    if (!rst) begin
      if (mem_wr_en) begin
        tests++;
        if (mem_wr_full) begin
          fails++;
          $display("FAIL wr_while_full: wr_en=1 with full=1");
        end
        tests++;
        if (exp_w.size() == 0) begin
          fails++;
          $display("FAIL extra_word: got mask=%b data=%h, none expected",
                   mem_wr_mask, mem_wr_data);
        end else begin
          ew = exp_w.pop_front();
          if ({mem_wr_mask, mem_wr_data} !== {ew.m, ew.d}) begin
            fails++;
            $display("FAIL word: got mask=%b data=%h expected mask=%b data=%h",
                     mem_wr_mask, mem_wr_data, ew.m, ew.d);
          end
        end
        if (words_seen == 0) first_m = mem_wr_mask;
        last_m = mem_wr_mask;
        words_seen++;
        pend_words++;
      end
      if (mem_cmd_en) begin
        tests++;
        if (mem_cmd_full || mem_cmd_instr != 3'b000) begin
          fails++;
          $display("FAIL cmd_strobe: full=%b instr=%b expected full=0 instr=000",
                   mem_cmd_full, mem_cmd_instr);
        end
        tests++;
        if (pend_words != int'(mem_cmd_bl) + 1) begin
          fails++;
          $display("FAIL burst_len: %0d words before cmd, bl=%0d",
                   pend_words, mem_cmd_bl);
        end
        pend_words = 0;
        tests++;
        if (exp_c.size() == 0) begin
          fails++;
          $display("FAIL extra_cmd: got bl=%0d addr=%h, none expected",
                   mem_cmd_bl, mem_cmd_byte_addr);
        end else begin
          ec = exp_c.pop_front();
          if ({mem_cmd_bl, mem_cmd_byte_addr} !== {ec.bl, ec.a}) begin
            fails++;
            $display("FAIL cmd: got bl=%0d addr=%h expected bl=%0d addr=%h",
                     mem_cmd_bl, mem_cmd_byte_addr, ec.bl, ec.a);
          end
        end
      end
      if (req_drop) drops_seen++;
    end
  end

  // Back-pressure generator.
  always @(posedge clk) begin
    #1;
    if (rand_full) begin
      mem_wr_full = ($urandom_range(0, 2) == 0);
      mem_cmd_full = ($urandom_range(0, 1) == 0);
    end else begin
      mem_wr_full = 1'b0;
      mem_cmd_full = 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_clear(input logic [7:0] c);
    wexp_t w;
    cexp_t k;
    for (int r = 0; r < 192; r++) begin
      for (int i = 0; i < 64; i++) begin
        w.m = 4'b0000;
        w.d = {4{c}};
        exp_w.push_back(w);
      end
      k.bl = 6'd63;
      k.a = {14'h0, 8'(r), 6'd0, 2'b00};
      exp_c.push_back(k);
    end
  endtask

  // Pixel-level model: each covered pixel clears its lane bit.
  task automatic model_req(input bit span, input int x, input int y,
                           input int len, input logic [7:0] rgb);
    int e;
    int w0;
    int w1;
    int n;
    wexp_t w;
    cexp_t k;
    if (y >= 192 || (span && len == 0)) return;
    e = span ? x + len : x + 1;
    if (e > 256) e = 256;
    w0 = x / 4;
    w1 = (e - 1) / 4;
    for (int wi = w0; wi <= w1; wi++) begin
      w.m = 4'hf;
      w.d = {4{rgb}};
      for (int p = x; p < e; p++)
        if (p / 4 == wi) w.m[p % 4] = 1'b0;
      exp_w.push_back(w);
    end
    for (int c = w0; c <= w1; c += 64) begin
      n = (w1 - c + 1 > 64) ? 64 : w1 - c + 1;
      k.bl = 6'(n - 1);
      k.a = {14'h0, 8'(y), 6'(c), 2'b00};
      exp_c.push_back(k);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (!(exp_w.size() == 0 && exp_c.size() == 0 &&
             req_ready && clear_done)) begin
      if (n >= budget) begin
        tests++;
        fails++;
        $display("FAIL %s_timeout: %0d words %0d cmds left, done=%b",
                 name, exp_w.size(), exp_c.size(), clear_done);
        break;
      end
      @(posedge clk);
      #2;
      n++;
    end
  endtask

  task automatic send(input bit span, input int x, input int y,
                      input int len, input logic [7:0] rgb);
    int n;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_span = span;
    req_x = 8'(x);
    req_y = 8'(y);
    req_len = 9'(len);
    req_rgb = rgb;
    n = 0;
    #1;
    while (!req_ready && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 100) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: req_ready stayed 0");
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic check_reset_outs(input string name);
    check({name, "_strobes"},
          {mem_wr_en, mem_cmd_en, clear_done, req_ready, req_drop}, 0);
    check({name, "_cmd"}, {mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr}, 0);
    check({name, "_wdata"}, {mem_wr_mask, mem_wr_data}, 0);
  endtask

  vec_t v[11];
  int   d0;
  int   n;

  initial begin
    v[0]  = '{1'b0, 50, 50, 0, 8'hff, 1'b0, 1, 1'b0, 4'b1011, 4'b1011};
    v[1]  = '{1'b1, 5, 3, 10, 8'h55, 1'b0, 3, 1'b0, 4'b0001, 4'b1000};
    v[2]  = '{1'b1, 250, 7, 20, 8'h92, 1'b0, 2, 1'b0, 4'b0011, 4'b0000};
    v[3]  = '{1'b1, 10, 200, 5, 8'h11, 1'b0, 0, 1'b1, 4'b0000, 4'b0000};
    v[4]  = '{1'b1, 10, 20, 0, 8'h22, 1'b0, 0, 1'b1, 4'b0000, 4'b0000};
    v[5]  = '{1'b0, 0, 191, 0, 8'h03, 1'b0, 1, 1'b0, 4'b1110, 4'b1110};
    v[6]  = '{1'b1, 3, 0, 2, 8'h44, 1'b0, 2, 1'b0, 4'b0111, 4'b1110};
    v[7]  = '{1'b1, 8, 1, 3, 8'h66, 1'b0, 1, 1'b0, 4'b1000, 4'b1000};
    v[8]  = '{1'b0, 7, 192, 0, 8'h77, 1'b0, 0, 1'b1, 4'b0000, 4'b0000};
    v[9]  = '{1'b1, 0, 100, 256, 8'h5a, 1'b1, 64, 1'b0, 4'b0000, 4'b0000};
    v[10] = '{1'b1, 1, 5, 300, 8'hc3, 1'b1, 64, 1'b0, 4'b0001, 4'b0000};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outs("reset");
    push_clear(8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    wait_idle(14000, "init_clear");
    check("init_done", clear_done, 1);

    for (int i = 0; i < 11; i++) begin
      words_seen = 0;
      d0 = drops_seen;
      model_req(v[i].span, v[i].x, v[i].y, v[i].len, v[i].rgb);
      rand_full = v[i].rf;
      send(v[i].span, v[i].x, v[i].y, v[i].len, v[i].rgb);
      #1;
      wait_idle(3000, "req");
      rand_full = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check($sformatf("v%0d_words", i), words_seen, v[i].nw);
      check($sformatf("v%0d_drop", i), drops_seen - d0, int'(v[i].drop));
      if (v[i].nw > 0) begin
        check($sformatf("v%0d_first_mask", i), first_m, v[i].m0);
        check($sformatf("v%0d_last_mask", i), last_m, v[i].m1);
      end
    end

    // Request and clear together in IDLE: clear wins.
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_span = 1'b0;
    req_x = 8'd1;
    req_y = 8'd1;
    clear_req = 1'b1;
    clear_rgb = 8'h1c;
    push_clear(8'h1c);
    #1;
    check("simul_ready", req_ready, 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    clear_req = 1'b0;
    #1;
    check("simul_done_low", clear_done, 0);
    wait_idle(14000, "simul_clear");
    check("simul_done", clear_done, 1);

    // Clear during a span, then reset during that clear.
    words_seen = 0;
    model_req(1'b1, 0, 10, 256, 8'h33);
    send(1'b1, 0, 10, 256, 8'h33);
    repeat (10) @(posedge clk);
    #1;
    clear_req = 1'b1;
    clear_rgb = 8'he0;
    push_clear(8'he0);
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    #1;
    check("mid_done_low", clear_done, 0);
    n = 0;
    while (words_seen < 264 && n < 1000) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("mid_clear_progress", words_seen >= 264, 1);
    rst = 1'b1;
    #1;
    exp_w.delete();
    exp_c.delete();
    pend_words = 0;
    check_reset_outs("midrst");
    push_clear(8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    wait_idle(14000, "rst_clear");
    check("rst_done", clear_done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
